// File: rtl/dbus_responder.sv
// Data-port responder for the core: byte-lane word RAM plus an MMIO window holding a
// free-running cycle counter, a UART TX FIFO and the TOHOST halt register.
module dbus_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  gated_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] d_w_addr,
  input  logic [DATA_WIDTH-1:0] d_w_dat,
  input  logic                  d_w_enb,
  input  logic [3:0]            d_w_byte_enb,
  input  logic [ADDR_WIDTH-1:0] d_r_addr,
  input  logic                  d_r_enb,
  output logic [DATA_WIDTH-1:0] d_r_dat,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  halt,
  output logic [DATA_WIDTH-1:0] tohost
);

  localparam int MIDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] REG_CYCLE_LO  = 3'd0;
  localparam logic [2:0] REG_CYCLE_HI  = 3'd1;
  localparam logic [2:0] REG_TX_DATA   = 3'd2;
  localparam logic [2:0] REG_TX_STATUS = 3'd3;
  localparam logic [2:0] REG_TOHOST    = 3'd4;

  localparam logic [3:0]       FIFO_FULL_CNT = 4'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(FIFO_DEPTH - 1);

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      else       res[8*i +: 8] = old_w[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return {PTR_W{1'b0}};
    else               return p + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];
  logic [7:0]            fifo_mem_r [FIFO_DEPTH];
  logic [63:0]           cycle_cnt_r;
  logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
  logic [3:0]            count_r;
  logic                  ovf_r, tx_valid_r, halt_r;
  logic [7:0]            tx_data_r;
  logic [DATA_WIDTH-1:0] tohost_r;

  logic                  w_mmio_s, r_mmio_s;
  logic [2:0]            w_reg_s, r_reg_s;
  logic [MIDX_W-1:0]     w_idx_s, r_idx_s;
  logic                  push_req_s, pop_s, push_ok_s, ovf_clr_s, tohost_wr_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [3:0]            count_nxt_s;
  logic                  ovf_nxt_s;
  logic [7:0]            tx_data_nxt_s;
  logic [DATA_WIDTH-1:0] status_s, rd_data_s;
  logic                  unused_addr_bits_s;

  assign w_mmio_s = d_w_addr[ADDR_WIDTH-1];
  assign r_mmio_s = d_r_addr[ADDR_WIDTH-1];
  assign w_reg_s  = d_w_addr[4:2];
  assign r_reg_s  = d_r_addr[4:2];
  assign w_idx_s  = d_w_addr[MIDX_W+1:2];
  assign r_idx_s  = d_r_addr[MIDX_W+1:2];
  assign unused_addr_bits_s = ^{d_w_addr[1:0], d_r_addr[1:0]};

  // FIFO and MMIO write-side next-state decode
  always_comb begin
    push_req_s  = d_w_enb && w_mmio_s && (w_reg_s == REG_TX_DATA) && d_w_byte_enb[0];
    pop_s       = tx_valid_r && tx_ready;
    push_ok_s   = push_req_s && ((count_r < FIFO_FULL_CNT) || pop_s);
    ovf_clr_s   = d_w_enb && w_mmio_s && (w_reg_s == REG_TX_STATUS) &&
                  d_w_byte_enb[0] && d_w_dat[2];
    tohost_wr_s = d_w_enb && w_mmio_s && (w_reg_s == REG_TOHOST);

    if (pop_s) rd_ptr_nxt_s = next_ptr(rd_ptr_r);
    else       rd_ptr_nxt_s = rd_ptr_r;
    if (push_ok_s) wr_ptr_nxt_s = next_ptr(wr_ptr_r);
    else           wr_ptr_nxt_s = wr_ptr_r;

    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + 4'd1;
      2'b01:   count_nxt_s = count_r - 4'd1;
      default: count_nxt_s = count_r;
    endcase

    // A dropped push must win over a clear that cannot legally coincide with it
    if (push_req_s && !push_ok_s) ovf_nxt_s = 1'b1;
    else if (ovf_clr_s)           ovf_nxt_s = 1'b0;
    else                          ovf_nxt_s = ovf_r;

    // New head bypasses storage when the pushed byte is the only one left
    if (push_ok_s && ((count_r - {3'b000, pop_s}) == 4'd0)) tx_data_nxt_s = d_w_dat[7:0];
    else if (count_nxt_s != 4'd0)                          tx_data_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
    else                                                   tx_data_nxt_s = tx_data_r;
  end

  // Byte-lane RAM write; contents survive reset
  always_ff @(posedge gated_clk) begin
    if (d_w_enb && !w_mmio_s) begin
      mem_r[w_idx_s] <= merge_lanes(mem_r[w_idx_s], d_w_dat, d_w_byte_enb);
    end
  end

  // TX FIFO storage
  always_ff @(posedge gated_clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= d_w_dat[7:0];
    end
  end

  // Counter, FIFO control and TOHOST state
  always_ff @(posedge gated_clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_r <= 64'd0;
      rd_ptr_r    <= {PTR_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= 4'd0;
      ovf_r       <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'd0;
      halt_r      <= 1'b0;
      tohost_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 64'd1;
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      count_r     <= count_nxt_s;
      ovf_r       <= ovf_nxt_s;
      tx_valid_r  <= (count_nxt_s != 4'd0);
      tx_data_r   <= tx_data_nxt_s;
      if (tohost_wr_s) begin
        tohost_r <= merge_lanes(tohost_r, d_w_dat, d_w_byte_enb);
        if (d_w_byte_enb != 4'b0000) halt_r <= 1'b1;
        else                         halt_r <= halt_r;
      end else begin
        tohost_r <= tohost_r;
        halt_r   <= halt_r;
      end
    end
  end

  assign status_s = DATA_WIDTH'({count_r, 1'b0, ovf_r, (count_r == 4'd0), (count_r == FIFO_FULL_CNT)});

  // Zero-latency read mux
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if (!d_r_enb) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else if (!r_mmio_s) begin
      rd_data_s = mem_r[r_idx_s];
    end else begin
      case (r_reg_s)
        REG_CYCLE_LO:  rd_data_s = DATA_WIDTH'(cycle_cnt_r[31:0]);
        REG_CYCLE_HI:  rd_data_s = DATA_WIDTH'(cycle_cnt_r[63:32]);
        REG_TX_STATUS: rd_data_s = status_s;
        REG_TOHOST:    rd_data_s = tohost_r;
        default:       rd_data_s = {DATA_WIDTH{1'b0}};
      endcase
    end
  end

  assign d_r_dat  = rd_data_s;
  assign tx_valid = tx_valid_r;
  assign tx_data  = tx_data_r;
  assign halt     = halt_r;
  assign tohost   = tohost_r;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder; TX bytes are scoreboarded through a queue.
module tb_dbus_responder;

  localparam logic [11:0] A_LO = 12'h800;
  localparam logic [11:0] A_HI = 12'h804;
  localparam logic [11:0] A_TX = 12'h808;
  localparam logic [11:0] A_ST = 12'h80C;
  localparam logic [11:0] A_TH = 12'h810;

  logic        gated_clk, rst, clk_run;
  logic [11:0] d_w_addr, d_r_addr;
  logic [31:0] d_w_dat, d_r_dat, tohost;
  logic        d_w_enb, d_r_enb, tx_valid, tx_ready, halt;
  logic [3:0]  d_w_byte_enb;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  dbus_responder dut (
    .gated_clk(gated_clk), .rst(rst),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
    .d_r_addr(d_r_addr), .d_r_enb(d_r_enb), .d_r_dat(d_r_dat),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .halt(halt), .tohost(tohost)
  );

  initial begin
    gated_clk = 1'b0;
    forever begin
      #5;
      if (clk_run) gated_clk = ~gated_clk;
      else         gated_clk = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge gated_clk);
    d_w_addr = a; d_w_dat = d; d_w_byte_enb = be; d_w_enb = 1'b1;
    @(posedge gated_clk); #1;
    d_w_enb = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge gated_clk);
    d_r_addr = a; d_r_enb = 1'b1; #1;
    d = d_r_dat;
    d_r_enb = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr(A_TX, {24'd0, b}, 4'b0001);
    exp_q.push_back(b);
  endtask

  task automatic drain(input int n, input string tag);
    logic [7:0] e;
    @(negedge gated_clk);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got valid=%b data=%h, expected valid=1 data=%h", tag, i, tx_valid, tx_data, e);
      end
      @(negedge gated_clk);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    d_r_addr = 12'h010; d_r_enb = 1'b0; #1;
    checks++;
    if (d_r_dat !== 32'd0) begin errors++; $display("FAIL reset_rdat: got %h expected 0", d_r_dat); end
    checks++;
    if ({tx_valid, tx_data, halt, tohost} !== 42'd0) begin
      errors++; $display("FAIL reset_outs: got valid=%b data=%h halt=%b tohost=%h expected all 0", tx_valid, tx_data, halt, tohost);
    end
    d_r_addr = A_ST; d_r_enb = 1'b1; #1;
    checks++;
    if (d_r_dat !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", d_r_dat); end
    d_r_addr = A_LO; #1;
    checks++;
    if (d_r_dat !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %h expected 0", d_r_dat); end
    d_r_enb = 1'b0;
    @(negedge gated_clk);
    rst = 1'b0;
  endtask

  task automatic test_ram;
    logic [31:0] v;
    wr(12'h010, 32'hAABBCCDD, 4'b1111);
    wr(12'h010, 32'h000000EE, 4'b0001);
    rd(12'h010, v);
    checks++; if (v !== 32'hAABBCCEE) begin errors++; $display("FAIL ram_lanes: got %h expected aabbccee", v); end
    rd(12'h012, v);
    checks++; if (v !== 32'hAABBCCEE) begin errors++; $display("FAIL ram_unaligned: got %h expected aabbccee", v); end
    d_r_addr = 12'h010; d_r_enb = 1'b0; #1;
    checks++; if (d_r_dat !== 32'd0) begin errors++; $display("FAIL ram_rd_disabled: got %h expected 0", d_r_dat); end
    wr(12'h020, 32'h55667788, 4'b1111);
    @(negedge gated_clk);
    d_w_addr = 12'h020; d_w_dat = 32'h11223344; d_w_byte_enb = 4'b1111; d_w_enb = 1'b1;
    d_r_addr = 12'h020; d_r_enb = 1'b1; #1;
    checks++; if (d_r_dat !== 32'h55667788) begin errors++; $display("FAIL ram_same_cycle: got %h expected 55667788", d_r_dat); end
    @(posedge gated_clk); #1;
    d_w_enb = 1'b0;
    checks++; if (d_r_dat !== 32'h11223344) begin errors++; $display("FAIL ram_next_cycle: got %h expected 11223344", d_r_dat); end
    d_r_enb = 1'b0;
    wr(12'h020, 32'hFFFFFFFF, 4'b0000);
    rd(12'h020, v);
    checks++; if (v !== 32'h11223344) begin errors++; $display("FAIL ram_be_zero: got %h expected 11223344", v); end
    wr(12'h014, 32'h12345678, 4'b1111);
    wr(12'h814, 32'hDEADBEEF, 4'b1111);
    rd(12'h014, v);
    checks++; if (v !== 32'h12345678) begin errors++; $display("FAIL ram_mmio_isolation: got %h expected 12345678", v); end
    rd(12'h814, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL mmio_reg5: got %h expected 0", v); end
  endtask

  task automatic test_counter;
    @(negedge gated_clk);
    rst = 1'b1; #1; rst = 1'b0;
    repeat (100) @(posedge gated_clk);
    @(negedge gated_clk);
    d_r_enb = 1'b1; d_r_addr = A_LO; #1;
    checks++; if (d_r_dat !== 32'd100) begin errors++; $display("FAIL cycle_lo_100: got %0d expected 100", d_r_dat); end
    d_r_addr = A_HI; #1;
    checks++; if (d_r_dat !== 32'd0) begin errors++; $display("FAIL cycle_hi_0: got %h expected 0", d_r_dat); end
    @(negedge gated_clk);
    force dut.cycle_cnt_r = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_cnt_r;
    @(posedge gated_clk); #1;
    d_r_addr = A_LO; #1;
    checks++; if (d_r_dat !== 32'd0) begin errors++; $display("FAIL cycle_carry_lo: got %h expected 0", d_r_dat); end
    d_r_addr = A_HI; #1;
    checks++; if (d_r_dat !== 32'd1) begin errors++; $display("FAIL cycle_carry_hi: got %h expected 1", d_r_dat); end
    @(negedge gated_clk);
    force dut.cycle_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.cycle_cnt_r;
    @(posedge gated_clk); #1;
    d_r_addr = A_HI; #1;
    checks++; if (d_r_dat !== 32'd0) begin errors++; $display("FAIL cycle_wrap: got hi=%h expected 0", d_r_dat); end
    d_r_enb = 1'b0;
  endtask

  task automatic test_fifo_fill_drain;
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i));
    rd(A_ST, v);
    checks++; if (v !== 32'h81) begin errors++; $display("FAIL fifo_full_status: got %h expected 00000081", v); end
    wr(A_TX, 32'h5A, 4'b1110);
    rd(A_ST, v);
    checks++; if (v !== 32'h81) begin errors++; $display("FAIL fifo_lane0_off: got %h expected 00000081", v); end
    wr(A_TX, 32'h49, 4'b0001);
    rd(A_ST, v);
    checks++; if (v !== 32'h85) begin errors++; $display("FAIL fifo_overflow: got %h expected 00000085", v); end
    drain(8, "fill_drain");
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h48) begin
      errors++; $display("FAIL fifo_empty_hold: got valid=%b data=%h expected valid=0 data=48", tx_valid, tx_data);
    end
    rd(A_ST, v);
    checks++; if (v !== 32'h06) begin errors++; $display("FAIL fifo_drained_status: got %h expected 00000006", v); end
    wr(A_ST, 32'h4, 4'b0001);
    rd(12'hFEC, v);
    checks++; if (v !== 32'h02) begin errors++; $display("FAIL fifo_ovf_clear_alias: got %h expected 00000002", v); end
    rd(A_TX, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL tx_data_read: got %h expected 0", v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [7:0]  e;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h60 + 8'(i));
    @(negedge gated_clk);
    d_w_addr = A_TX; d_w_dat = 32'h50; d_w_byte_enb = 4'b0001; d_w_enb = 1'b1; tx_ready = 1'b1;
    e = exp_q.pop_front();
    exp_q.push_back(8'h50);
    checks++; if (tx_data !== e) begin errors++; $display("FAIL b2b_head: got %h expected %h", tx_data, e); end
    @(posedge gated_clk); #1;
    d_w_enb = 1'b0; tx_ready = 1'b0;
    rd(A_ST, v);
    checks++; if (v !== 32'h81) begin errors++; $display("FAIL b2b_status: got %h expected 00000081", v); end
    drain(8, "b2b_drain");
    rd(A_ST, v);
    checks++; if (v !== 32'h02) begin errors++; $display("FAIL b2b_empty: got %h expected 00000002", v); end
  endtask

  task automatic test_tohost;
    logic [31:0] v;
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_initial: got %b expected 0", halt); end
    wr(A_TH, 32'h00000001, 4'b1111);
    checks++;
    if (halt !== 1'b1 || tohost !== 32'h1) begin errors++; $display("FAIL tohost_first: got halt=%b tohost=%h expected 1/00000001", halt, tohost); end
    wr(A_TH, 32'h00000200, 4'b0010);
    checks++;
    if (halt !== 1'b1 || tohost !== 32'h201) begin errors++; $display("FAIL tohost_merge: got halt=%b tohost=%h expected 1/00000201", halt, tohost); end
    rd(A_TH, v);
    checks++; if (v !== 32'h201) begin errors++; $display("FAIL tohost_read: got %h expected 00000201", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i));
    drain(1, "mid_drain");
    #2 rst = 1'b1; #1;
    checks++;
    if (tx_valid !== 1'b0 || halt !== 1'b0 || tohost !== 32'd0) begin
      errors++; $display("FAIL rst_mid_outs: got valid=%b halt=%b tohost=%h expected 0/0/0", tx_valid, halt, tohost);
    end
    d_r_enb = 1'b1; d_r_addr = A_LO; #1;
    checks++; if (d_r_dat !== 32'd0) begin errors++; $display("FAIL rst_mid_cycle: got %h expected 0", d_r_dat); end
    d_r_addr = A_ST; #1;
    checks++; if (d_r_dat !== 32'h02) begin errors++; $display("FAIL rst_mid_status: got %h expected 00000002", d_r_dat); end
    d_r_enb = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    rd(12'h010, v);
    checks++; if (v !== 32'hAABBCCEE) begin errors++; $display("FAIL rst_ram_kept: got %h expected aabbccee", v); end
  endtask

  task automatic test_gating;
    tx_ready = 1'b0;
    @(negedge gated_clk);
    rst = 1'b1; #1; rst = 1'b0;
    push_byte(8'h77);
    repeat (8) @(posedge gated_clk);
    @(negedge gated_clk);
    d_r_enb = 1'b1; d_r_addr = A_LO; #1;
    checks++; if (d_r_dat !== 32'd10) begin errors++; $display("FAIL gate_pre: got %0d expected 10", d_r_dat); end
    clk_run = 1'b0;
    tx_ready = 1'b1;
    #200;
    checks++; if (d_r_dat !== 32'd10) begin errors++; $display("FAIL gate_frozen: got %0d expected 10", d_r_dat); end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      errors++; $display("FAIL gate_tx_stable: got valid=%b data=%h expected 1/77", tx_valid, tx_data);
    end
    tx_ready = 1'b0;
    clk_run = 1'b1;
    @(posedge gated_clk); #1;
    checks++; if (d_r_dat !== 32'd11) begin errors++; $display("FAIL gate_resume: got %0d expected 11", d_r_dat); end
    d_r_enb = 1'b0;
    drain(1, "gate_drain");
  endtask

  initial begin
    clk_run = 1'b1; rst = 1'b1; tx_ready = 1'b0;
    d_w_addr = 12'd0; d_w_dat = 32'd0; d_w_enb = 1'b0; d_w_byte_enb = 4'd0;
    d_r_addr = 12'd0; d_r_enb = 1'b0;
    test_reset();
    test_ram();
    test_counter();
    test_fifo_fill_drain();
    test_back_to_back();
    test_tohost();
    test_reset_mid();
    test_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
